// File: rtl/hazard_unit.sv
// Hazard and forwarding controller: shadows EX/MEM/WB destination info, drives the
// EX operand-mux selects, and raises load-use stall / taken-branch flush controls.
// Define HAZARD_STATS_EN to add saturating stall/flush statistics counters.

module hazard_fwd_sel #(
    parameter int W = 5
) (
    input  logic [W-1:0] src,
    input  logic [W-1:0] mem_rd,
    input  logic         mem_we,
    input  logic [W-1:0] wb_rd,
    input  logic         wb_we,
    output logic [1:0]   sel
);
    // The youngest producer (MEM) wins; x0 is hardwired and never forwarded.
    always_comb begin
        sel = 2'd0;
        if (src != '0) begin
            if (mem_we && mem_rd == src)
                sel = 2'd2;
            else if (wb_we && wb_rd == src)
                sel = 2'd1;
        end
    end
endmodule

module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STATS_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      reg_write_d,
    input  logic                      load_d,
    input  logic                      branch_taken_e,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
`ifdef HAZARD_STATS_EN
    output logic                      flush_e,
    output logic [STATS_WIDTH-1:0]    stall_count,
    output logic [STATS_WIDTH-1:0]    flush_count
`else
    output logic                      flush_e
`endif
);
    localparam int W = REG_ADDR_WIDTH;

    typedef struct packed {
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic [W-1:0] rd;
        logic         we;
        logic         ld;
    } ex_ent_t;

    typedef struct packed {
        logic [W-1:0] rd;
        logic         we;
    } wr_ent_t;

    ex_ent_t ex_q;
    wr_ent_t mem_q, wb_q;

    logic             lu;
    logic             br;
    logic [1:0][W-1:0] src;
    logic [1:0][1:0]   sel;

    assign src[0] = ex_q.rs1;
    assign src[1] = ex_q.rs2;

    for (genvar g = 0; g < 2; g++) begin : g_op
        hazard_fwd_sel #(.W(W)) u_sel (
            .src    (src[g]),
            .mem_rd (mem_q.rd),
            .mem_we (mem_q.we),
            .wb_rd  (wb_q.rd),
            .wb_we  (wb_q.we),
            .sel    (sel[g])
        );
    end

    // Conservative: both D sources are compared whether or not they are read.
    assign lu = ex_q.ld && (ex_q.rd != '0) && (ex_q.rd == rs1_d || ex_q.rd == rs2_d);
    assign br = branch_taken_e;

    assign forward_a_e = rst ? 2'd0 : sel[0];
    assign forward_b_e = rst ? 2'd0 : sel[1];
    // A taken branch discards the D instruction, so a coincident load-use never stalls.
    assign stall_f     = !rst && lu && !br;
    assign stall_d     = !rst && lu && !br;
    assign flush_d     = !rst && br;
    assign flush_e     = !rst && (lu || br);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{rd: ex_q.rd, we: ex_q.we};
            if (flush_e)
                ex_q <= '0;
            else
                ex_q <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, we: reg_write_d, ld: load_d};
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STATS_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (branch_taken_e && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_count = rst ? '0 : stall_cnt_q;
    assign flush_count = rst ? '0 : flush_cnt_q;
`else
    logic [STATS_WIDTH-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against an instruction-history model.
module tb_hazard_unit;
    localparam int AW = 5;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
    logic reg_write_d = 1'b0, load_d = 1'b0, branch_taken_e = 1'b0;
    logic [1:0] forward_a_e, forward_b_e;
    logic stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_STATS_EN
    logic [SW-1:0] stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_WIDTH(AW), .STATS_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .load_d(load_d), .branch_taken_e(branch_taken_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
`ifdef HAZARD_STATS_EN
        .flush_e(flush_e), .stall_count(stall_count), .flush_count(flush_count)
`else
        .flush_e(flush_e)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] rs1, rs2, rd;
        logic          we, ld;
    } ins_t;

    typedef struct packed {
        logic [1:0]    fa, fb;
        logic          sf, sd, fd, fe;
        logic [SW-1:0] sc, fc;
    } exp_t;

    // Instructions that entered EX, youngest first: [0]=EX, [1]=MEM, [2]=WB.
    ins_t hist[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int unsigned sc_m = 0, fc_m = 0;
    localparam int unsigned SAT = (1 << SW) - 1;

    function automatic logic [1:0] fwd(input logic [AW-1:0] src);
        if (src == 0) return 2'd0;
        for (int age = 1; age <= 2; age++)
            if (hist[age].we && hist[age].rd == src)
                return (age == 1) ? 2'd2 : 2'd1;
        return 2'd0;
    endfunction

    function automatic void chk(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, req, $time);
        end
    endfunction

    task automatic step(input ins_t i, input logic br, input logic r, output logic stalled);
        exp_t e;
        logic lu;
        ins_t bub;
        bub = '0;
        @(negedge clk);
        rs1_d = i.rs1; rs2_d = i.rs2; rd_d = i.rd;
        reg_write_d = i.we; load_d = i.ld;
        branch_taken_e = br; rst = r;
        e = '0;
        if (!r) begin
            lu   = hist[0].ld && hist[0].rd != 0 && (hist[0].rd == i.rs1 || hist[0].rd == i.rs2);
            e.fa = fwd(hist[0].rs1);
            e.fb = fwd(hist[0].rs2);
            e.sf = lu && !br;
            e.sd = lu && !br;
            e.fd = br;
            e.fe = lu || br;
            e.sc = SW'(sc_m);
            e.fc = SW'(fc_m);
        end
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            hist = '{bub, bub, bub};
            sc_m = 0;
            fc_m = 0;
        end else begin
            hist.push_front(e.fe ? bub : i);
            void'(hist.pop_back());
            if (e.sd && sc_m != SAT) sc_m++;
            if (br && fc_m != SAT) fc_m++;
        end
        stalled = e.sd;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("forward_a_e", forward_a_e, e.fa);
            chk("forward_b_e", forward_b_e, e.fb);
            chk("stall_f", stall_f, e.sf);
            chk("stall_d", stall_d, e.sd);
            chk("flush_d", flush_d, e.fd);
            chk("flush_e", flush_e, e.fe);
`ifdef HAZARD_STATS_EN
            chk("stall_count", stall_count, e.sc);
            chk("flush_count", flush_count, e.fc);
`endif
        end
    end

    function automatic ins_t mk(input int a, input int b, input int d, input bit w, input bit l);
        ins_t i;
        i.rs1 = AW'(a); i.rs2 = AW'(b); i.rd = AW'(d); i.we = w; i.ld = l;
        return i;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic st, hold, br, r;
        ins_t cur, nop;
        nop = '0;
        hist = '{nop, nop, nop};
        // reset with arbitrary inputs, then one quiet cycle
        step(mk(3, 4, 5, 1, 1), 1'b1, 1'b1, st);
        step(mk(7, 2, 9, 1, 0), 1'b0, 1'b1, st);
        step(nop, 1'b0, 1'b0, st);
        // add x5; sub rs1=x5; or rs2=x5
        step(mk(1, 2, 5, 1, 0), 1'b0, 1'b0, st);
        step(mk(5, 3, 8, 1, 0), 1'b0, 1'b0, st);
        step(mk(4, 5, 10, 1, 0), 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        // x0 writer then x0 consumer
        step(mk(1, 2, 0, 1, 0), 1'b0, 1'b0, st);
        step(mk(0, 0, 11, 1, 0), 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        // lw x6; consumer rs2=x6 held during the stall
        step(mk(1, 0, 6, 1, 1), 1'b0, 1'b0, st);
        cur = mk(2, 6, 12, 1, 0);
        step(cur, 1'b0, 1'b0, st);
        while (st) step(cur, 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        // load-use coinciding with a taken branch
        step(mk(1, 0, 6, 1, 1), 1'b0, 1'b0, st);
        step(mk(6, 0, 12, 1, 0), 1'b1, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        // MEM and WB both writing x7
        step(mk(1, 2, 7, 1, 0), 1'b0, 1'b0, st);
        step(mk(3, 4, 7, 1, 0), 1'b0, 1'b0, st);
        step(mk(7, 0, 13, 1, 0), 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        step(nop, 1'b0, 1'b0, st);
        // random traffic over a small register set to provoke hazards
        hold = 1'b0;
        cur = nop;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom % 97) == 0;
            br = ($urandom % 8) == 0;
            if (!hold) begin
                cur.rs1 = AW'($urandom % 8);
                cur.rs2 = AW'($urandom % 8);
                cur.rd  = AW'($urandom % 8);
                cur.ld  = ($urandom % 4) == 0;
                cur.we  = cur.ld || (($urandom % 4) != 0);
            end
            step(cur, br, r, st);
            hold = st;
        end
        step(nop, 1'b0, 1'b0, st);
        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
